// File: rtl/pic_q_pkg.sv
// ============================================================================
// Module  : pic_q_pkg
// Brief   : Shared types and constants for the port Q-phase latch block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pic_q_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Q1   = 3'd1,
        Q2   = 3'd2,
        Q3   = 3'd3,
        Q4   = 3'd4
    } phase_t;

    localparam logic       SEL_PORT         = 1'b0;
    localparam logic       SEL_TRIS         = 1'b1;
    localparam logic [7:0] TRIS_RST_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/pin_sync.sv
// ============================================================================
// Module  : pin_sync
// Brief   : WIDTH x SYNC_LEN flop synchroniser with async active-high clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pin_sync #(
    parameter int WIDTH    = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 sits in the low WIDTH bits; the oldest stage is the top slice.
    logic [SYNC_LEN*WIDTH-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[(SYNC_LEN-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_LEN*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/port_q_latch.sv
// ============================================================================
// Module  : port_q_latch
// Brief   : Q1..Q4 phase sequencer with PORT/TRIS latches feeding pin drivers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module port_q_latch
    import pic_q_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TRIS_RST = WIDTH'(TRIS_RST_DEFAULT),
    parameter int               SYNC_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] pin_in,
    output logic             q1,
    output logic             q2,
    output logic             q3,
    output logic             q4,
    output logic [WIDTH-1:0] pin_drv,
    output logic [WIDTH-1:0] pin_oe,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_ack
);

    phase_t           r_state;
    phase_t           w_next;
    logic [3:0]       w_q_next;
    logic [3:0]       r_q;
    logic [WIDTH-1:0] r_port;
    logic [WIDTH-1:0] r_tris;
    logic             r_pend;
    logic             r_pend_sel;
    logic [WIDTH-1:0] r_pend_data;
    logic [WIDTH-1:0] r_rd;
    logic             r_ack;
    logic [WIDTH-1:0] w_sync_pins;

    pin_sync #(
        .WIDTH    (WIDTH),
        .SYNC_LEN (SYNC_LEN)
    ) u_pin_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pin_in),
        .o_q (w_sync_pins)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are registered from the next state so they line up with r_state.
    always_comb begin
        w_next   = Q1;
        w_q_next = 4'b0000;
        unique case (r_state)
            IDLE:    w_next = Q1;
            Q1:      w_next = Q2;
            Q2:      w_next = Q3;
            Q3:      w_next = Q4;
            Q4:      w_next = Q1;
            default: w_next = Q1;
        endcase
        unique case (w_next)
            Q1:      w_q_next = 4'b0001;
            Q2:      w_q_next = 4'b0010;
            Q3:      w_q_next = 4'b0100;
            Q4:      w_q_next = 4'b1000;
            default: w_q_next = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= 4'b0000;
            r_port      <= '0;
            r_tris      <= TRIS_RST;
            r_pend      <= 1'b0;
            r_pend_sel  <= SEL_PORT;
            r_pend_data <= '0;
            r_rd        <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_ack <= 1'b0;
            // Read and capture share the Q2 exit; the read sees pre-write latches.
            if (r_state == Q2) begin
                r_rd <= (w_sync_pins & r_tris) | (r_port & ~r_tris);
                if (wr_en) begin
                    r_pend      <= 1'b1;
                    r_pend_sel  <= wr_sel;
                    r_pend_data <= wr_data;
                end
            end
            if ((r_state == Q4) && r_pend) begin
                if (r_pend_sel == SEL_TRIS) begin
                    r_tris <= r_pend_data;
                end else begin
                    r_port <= r_pend_data;
                end
                r_pend <= 1'b0;
                r_ack  <= 1'b1;
            end
        end
    end

    assign q1      = r_q[0];
    assign q2      = r_q[1];
    assign q3      = r_q[2];
    assign q4      = r_q[3];
    assign pin_oe  = ~r_tris;
    assign pin_drv = r_port & ~r_tris;
    assign rd_data = r_rd;
    assign wr_ack  = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_port_q_latch.sv
// ============================================================================
// Module  : tb_port_q_latch
// Brief   : Self-checking bench for port_q_latch against a phase-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_port_q_latch;

    localparam int SYNC_LEN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] pin_in = 8'h00;
    logic       q1, q2, q3, q4;
    logic [7:0] pin_drv, pin_oe, rd_data;
    logic       wr_ack;

    port_q_latch #(
        .WIDTH    (8),
        .TRIS_RST (8'hFF),
        .SYNC_LEN (SYNC_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .pin_in  (pin_in),
        .q1      (q1),
        .q2      (q2),
        .q3      (q3),
        .q4      (q4),
        .pin_drv (pin_drv),
        .pin_oe  (pin_oe),
        .rd_data (rd_data),
        .wr_ack  (wr_ack)
    );

    always #5 clk = ~clk;

    // Reference model: phase number 0 = idle, 1..4 = Q1..Q4.
    int         m_ph;
    logic [7:0] m_port, m_tris, m_rd, m_pdata;
    logic       m_pend, m_psel, m_ack;
    logic [7:0] hist[$];

    int passed = 0;
    int total  = 0;
    int dut_acks = 0;
    bit rand_pins = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ph = 0; m_port = 8'h00; m_tris = 8'hFF; m_rd = 8'h00;
        m_pend = 1'b0; m_psel = 1'b0; m_pdata = 8'h00; m_ack = 1'b0;
        hist.delete();
    endtask

    function automatic logic [7:0] model_sync();
        if (hist.size() >= SYNC_LEN) return hist[hist.size()-SYNC_LEN];
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_q();
        if (m_ph == 0) return 8'h00;
        return 8'(1 << (m_ph - 1));
    endfunction

    task automatic check_all();
        chk("q_phase", {4'b0, q4, q3, q2, q1}, exp_q());
        chk("pin_oe",  pin_oe,  ~m_tris);
        chk("pin_drv", pin_drv, m_port & ~m_tris);
        chk("rd_data", rd_data, m_rd);
        chk("wr_ack",  {7'b0, wr_ack}, {7'b0, m_ack});
    endtask

    task automatic tick();
        logic [7:0] sync_before;
        int old;
        sync_before = model_sync();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(pin_in);
            if (hist.size() > 4) void'(hist.pop_front());
            old   = m_ph;
            m_ph  = (m_ph == 0 || m_ph == 4) ? 1 : m_ph + 1;
            m_ack = 1'b0;
            if (old == 2) begin
                m_rd = (sync_before & m_tris) | (m_port & ~m_tris);
                if (wr_en) begin
                    m_pend = 1'b1; m_psel = wr_sel; m_pdata = wr_data;
                end
            end
            if (old == 4 && m_pend) begin
                if (m_psel) m_tris = m_pdata;
                else        m_port = m_pdata;
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end
        end
        #1;
        check_all();
        if (wr_ack) dut_acks++;
        if (rand_pins) pin_in = 8'($urandom);
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_ph != p && n < 10) begin
            tick();
            n++;
        end
        chk("phase_reach", {4'b0, q4, q3, q2, q1}, 8'(1 << (p - 1)));
    endtask

    task automatic do_write(input logic sel, input logic [7:0] data);
        wait_phase(2);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        tick();
        wr_en = 1'b0; wr_data = 8'($urandom);
    endtask

    task automatic hold_reset_and_release();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        model_reset();

        // Reset values and phase sequence after release
        tick();
        hold_reset_and_release();
        chk("rst_pin_oe",  pin_oe,  8'h00);
        chk("rst_pin_drv", pin_drv, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("onehot_seq", {4'b0, q4, q3, q2, q1}, {4'b0, seq[i]});
        end

        // TRIS = 0F then PORT = A5 on consecutive instruction cycles
        dut_acks = 0;
        do_write(1'b1, 8'h0F);
        do_write(1'b0, 8'hA5);
        wait_phase(1);
        chk("wr_pin_oe",  pin_oe,  8'hF0);
        chk("wr_pin_drv", pin_drv, 8'hA0);
        chk("wr_acks",    8'(dut_acks), 8'd2);

        // wr_en only during Q3 is ignored
        dut_acks = 0;
        wait_phase(3);
        wr_en = 1'b1; wr_sel = 1'($urandom); wr_data = 8'($urandom);
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("q3_acks",    8'(dut_acks), 8'd0);
        chk("q3_pin_oe",  pin_oe,  8'hF0);
        chk("q3_pin_drv", pin_drv, 8'hA0);

        // Read mux with held pin level
        rand_pins = 1'b0;
        pin_in = 8'h3C;
        for (int i = 0; i < 8; i++) tick();
        wait_phase(3);
        chk("rd_mix", rd_data, 8'hAC);
        rand_pins = 1'b1;

        // Pending write discarded by reset during Q3
        dut_acks = 0;
        do_write(1'b0, 8'hFF);
        hold_reset_and_release();
        tick();
        chk("rst_first_q1", {4'b0, q4, q3, q2, q1}, 8'h01);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_no_ack", 8'(dut_acks), 8'd0);
        do_write(1'b1, 8'h00);
        wait_phase(1);
        chk("rst_port_kept", pin_drv, 8'h00);
        chk("rst_tris_oe",   pin_oe,  8'hFF);

        // wr_en held across three instruction cycles
        dut_acks = 0;
        wait_phase(2);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        wait_phase(2);
        tick();
        wr_data = 8'h33;
        wait_phase(2);
        tick();
        wr_en = 1'b0;
        wait_phase(2);
        chk("held_acks",    8'(dut_acks), 8'd3);
        chk("held_pin_drv", pin_drv, 8'h33);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_sel  = 1'($urandom);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;

        // Reset from a random phase, then more traffic
        hold_reset_and_release();
        for (int i = 0; i < 60; i++) begin
            wr_en   = ($urandom_range(0, 1) == 0);
            wr_sel  = 1'($urandom);
            wr_data = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
